// File: rtl/gpc_pkg.sv
// Shared definitions for the gpc_stack program counter: command priority
// encoding, default geometry and the RAS stack-pointer width helper.
package gpc_pkg;

    localparam int unsigned GPC_DEF_WIDTH = 16;
    localparam int unsigned GPC_DEF_DEPTH = 4;

    // Ordered lowest to highest priority.
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_INC,
        CMD_BR,
        CMD_RET,
        CMD_CALL,
        CMD_LOAD
    } cmd_e;

    // sp counts 0..DEPTH inclusive, so it needs one bit more than the index.
    function automatic int unsigned sp_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/gpc_ras.sv
// Return-address stack: register-array LIFO with occupancy count and sticky
// overflow/underflow flags. Push takes precedence if push and pop are both high.
module gpc_ras import gpc_pkg::*; #(
    parameter int unsigned WIDTH = GPC_DEF_WIDTH,
    parameter int unsigned DEPTH = GPC_DEF_DEPTH
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [WIDTH-1:0]              data_i,
    output logic [WIDTH-1:0]              data_o,
    output logic [sp_width(DEPTH)-1:0]    sp_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          overflow_o,
    output logic                          underflow_o
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned SPW = sp_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SPW-1:0]   sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             do_push;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign full_o      = (sp_q == SPW'(DEPTH));
    assign empty_o     = (sp_q == '0);
    assign do_push     = push_i && !full_o;
    assign wr_idx      = sp_q[AW-1:0];
    assign rd_idx      = AW'(sp_q - SPW'(1));
    assign data_o      = mem_q[rd_idx];
    assign sp_o        = sp_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;

    always_comb begin
        sp_d  = sp_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (push_i) begin
            if (full_o) ovf_d = 1'b1;
            else        sp_d  = sp_q + SPW'(1);
        end else if (pop_i) begin
            if (empty_o) udf_d = 1'b1;
            else         sp_d  = sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Contents are meaningless after reset, so the array carries no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_idx] <= data_i;
    end

endmodule

// File: rtl/gpc_stack.sv
// Program counter with load/increment/relative branch and call/return via gpc_ras.
// Optional GPC_WRAP_DET_EN adds a registered 'wrap' output flagging adder wrap.
module gpc_stack import gpc_pkg::*; #(
    parameter int unsigned      WIDTH    = GPC_DEF_WIDTH,
    parameter int unsigned      DEPTH    = GPC_DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic                       increment,
    input  logic                       branch,
    input  logic                       call,
    input  logic                       ret,
    input  logic [WIDTH-1:0]           w,
    output logic [WIDTH-1:0]           y,
    output logic [sp_width(DEPTH)-1:0] sp,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
`ifdef GPC_WRAP_DET_EN
    ,
    output logic                       wrap
`endif
);

    cmd_e             cmd;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] y_inc;
    logic [WIDTH-1:0] y_sum;
    logic [WIDTH-1:0] ras_top;

    always_comb begin
        if      (load)      cmd = CMD_LOAD;
        else if (call)      cmd = CMD_CALL;
        else if (ret)       cmd = CMD_RET;
        else if (branch)    cmd = CMD_BR;
        else if (increment) cmd = CMD_INC;
        else                cmd = CMD_NONE;
    end

    assign y_inc = y_q + WIDTH'(1);
    assign y_sum = y_q + w;

    gpc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (cmd == CMD_CALL),
        .pop_i       (cmd == CMD_RET),
        .data_i      (y_inc),
        .data_o      (ras_top),
        .sp_o        (sp),
        .full_o      (full),
        .empty_o     (empty),
        .overflow_o  (overflow),
        .underflow_o (underflow)
    );

    always_comb begin
        y_d = y_q;
        case (cmd)
            CMD_LOAD, CMD_CALL: y_d = w;
            CMD_RET:            if (!empty) y_d = ras_top;
            CMD_BR:             y_d = y_sum;
            CMD_INC:            y_d = y_inc;
            default:            y_d = y_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) y_q <= RESET_PC;
        else        y_q <= y_d;
    end

    assign y = y_q;

`ifdef GPC_WRAP_DET_EN
    logic wrap_q, wrap_d;

    // Increment wraps on unsigned carry; branch wraps on signed overflow.
    always_comb begin
        wrap_d = 1'b0;
        case (cmd)
            CMD_INC: wrap_d = &y_q;
            CMD_BR:  wrap_d = (y_q[WIDTH-1] == w[WIDTH-1]) && (y_sum[WIDTH-1] != y_q[WIDTH-1]);
            default: wrap_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wrap_q <= 1'b0;
        else        wrap_q <= wrap_d;
    end

    assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_gpc_stack.sv
// Scoreboard bench for gpc_stack (WIDTH=16, DEPTH=4, RESET_PC=0); a queue-based
// reference model predicts every cycle, table tests also check literal y values.
module tb_gpc_stack;

    localparam logic [4:0] N = 5'b00000;
    localparam logic [4:0] L = 5'b10000;
    localparam logic [4:0] C = 5'b01000;
    localparam logic [4:0] R = 5'b00100;
    localparam logic [4:0] B = 5'b00010;
    localparam logic [4:0] I = 5'b00001;

    typedef struct packed {
        logic [15:0] y;
        logic [2:0]  sp;
        logic        empty;
        logic        full;
        logic        ov;
        logic        un;
        logic        wr;
    } obs_t;

    typedef struct packed {
        logic [4:0]  c;
        logic [15:0] w;
        logic [15:0] ey;
    } stim_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0, increment = 1'b0, branch = 1'b0, call = 1'b0, ret = 1'b0;
    logic [15:0] w = '0;
    logic [15:0] y;
    logic [2:0]  sp;
    logic        empty, full, overflow, underflow;
`ifdef GPC_WRAP_DET_EN
    logic        wrap;
`endif

    int n_cmp = 0;
    int n_err = 0;

    obs_t        sb[$];
    logic [15:0] m_y = '0;
    logic [15:0] m_ras[$];
    logic        m_ov = 1'b0, m_un = 1'b0, m_wr = 1'b0;

    gpc_stack #(
        .WIDTH    (16),
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .increment (increment),
        .branch    (branch),
        .call      (call),
        .ret       (ret),
        .w         (w),
        .y         (y),
        .sp        (sp),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef GPC_WRAP_DET_EN
        ,
        .wrap      (wrap)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    function automatic obs_t observe();
        obs_t o;
        o.y = y; o.sp = sp; o.empty = empty; o.full = full;
        o.ov = overflow; o.un = underflow;
`ifdef GPC_WRAP_DET_EN
        o.wr = wrap;
`else
        o.wr = 1'b0;
`endif
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.y = m_y;
        o.sp = 3'(m_ras.size());
        o.empty = (m_ras.size() == 0);
        o.full = (m_ras.size() == 4);
        o.ov = m_ov; o.un = m_un;
`ifdef GPC_WRAP_DET_EN
        o.wr = m_wr;
`else
        o.wr = 1'b0;
`endif
        return o;
    endfunction

    task automatic model_reset();
        m_y = 16'h0000; m_ras.delete();
        m_ov = 1'b0; m_un = 1'b0; m_wr = 1'b0;
    endtask

    task automatic model_step(input logic [4:0] c, input logic [15:0] wv);
        logic [15:0] ny;
        logic        nw;
        ny = m_y; nw = 1'b0;
        if (c[4]) ny = wv;
        else if (c[3]) begin
            if (m_ras.size() < 4) m_ras.push_back(m_y + 16'd1);
            else m_ov = 1'b1;
            ny = wv;
        end else if (c[2]) begin
            if (m_ras.size() > 0) ny = m_ras.pop_back();
            else m_un = 1'b1;
        end else if (c[1]) begin
            ny = m_y + wv;
            nw = (m_y[15] == wv[15]) && (ny[15] != m_y[15]);
        end else if (c[0]) begin
            ny = m_y + 16'd1;
            nw = (m_y == 16'hFFFF);
        end
        m_y = ny; m_wr = nw;
    endtask

    // Drive one command for one cycle; expectation queued as it is driven.
    task automatic drive(input logic [4:0] c, input logic [15:0] wv);
        {load, call, ret, branch, increment} = c;
        w = wv;
        model_step(c, wv);
        sb.push_back(model_obs());
        @(posedge clk);
        #1;
        {load, call, ret, branch, increment} = 5'b0;
    endtask

    task automatic test_reset();
        stim_t tbl [3] = '{'{C, 16'h0100, 16'h0100}, '{C, 16'h0200, 16'h0200},
                           '{L, 16'h1234, 16'h1234}};
        obs_t e, o;
        #2;
        o = observe(); n_cmp++;
        if (o !== 28'h0000_0200 >> 0 && o !== obs_t'{16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset_initial: got %h expected %h", o,
                              obs_t'{16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        reset = 1'b1;
        @(posedge clk); #1;
        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].w);
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL reset_setup[%0d]: got %h expected %h", i, o, e); end
            n_cmp++;
            if (y !== tbl[i].ey) begin n_err++; $display("FAIL reset_setup_y[%0d]: got %h expected %h", i, y, tbl[i].ey); end
        end
        // Mid-cycle async reset with y=0x1234, sp=2: must clear before any edge.
        reset = 1'b0;
        #2;
        model_reset();
        o = observe(); n_cmp++;
        if (o !== obs_t'{16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset_async: got %h expected %h", o,
                              obs_t'{16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        reset = 1'b1;
        drive(N, 16'h0000);
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL reset_release: got %h expected %h", o, e); end
    endtask

    task automatic test_load_inc();
        stim_t tbl [5] = '{'{L, 16'hAAAA, 16'hAAAA}, '{I, 16'h0000, 16'hAAAB},
                           '{I, 16'h0000, 16'hAAAC}, '{I, 16'h0000, 16'hAAAD},
                           '{L | I, 16'h5555, 16'h5555}};
        obs_t e, o;
        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].w);
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL load_inc[%0d]: got %h expected %h", i, o, e); end
            n_cmp++;
            if (y !== tbl[i].ey) begin n_err++; $display("FAIL load_inc_y[%0d]: got %h expected %h", i, y, tbl[i].ey); end
        end
    endtask

    task automatic test_branch_wrap();
        stim_t tbl [11] = '{'{L, 16'h0100, 16'h0100}, '{B, 16'hFFFE, 16'h00FE},
                            '{L, 16'hFFFF, 16'hFFFF}, '{I, 16'h0000, 16'h0000},
                            '{N, 16'h0000, 16'h0000}, '{B, 16'hFFFF, 16'hFFFF},
                            '{L, 16'h7FFF, 16'h7FFF}, '{B, 16'h0001, 16'h8000},
                            '{B | I, 16'h8000, 16'h0000}, '{L, 16'hFFFF, 16'hFFFF},
                            '{B, 16'h0001, 16'h0000}};
        obs_t e, o;
        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].w);
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL branch_wrap[%0d]: got %h expected %h", i, o, e); end
            n_cmp++;
            if (y !== tbl[i].ey) begin n_err++; $display("FAIL branch_wrap_y[%0d]: got %h expected %h", i, y, tbl[i].ey); end
        end
    endtask

    task automatic test_call_ret();
        stim_t tbl [10] = '{'{L, 16'h0010, 16'h0010}, '{C, 16'h0200, 16'h0200},
                            '{C, 16'h0300, 16'h0300}, '{R, 16'h0000, 16'h0201},
                            '{R, 16'h0000, 16'h0011}, '{C, 16'h0400, 16'h0400},
                            '{R, 16'h0000, 16'h0012}, '{C | R | B | I, 16'h0500, 16'h0500},
                            '{R | B | I, 16'h0010, 16'h0013}, '{B | I, 16'h0002, 16'h0015}};
        logic [2:0] esp [10] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd0};
        obs_t e, o;
        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].w);
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL call_ret[%0d]: got %h expected %h", i, o, e); end
            n_cmp++;
            if (y !== tbl[i].ey || sp !== esp[i]) begin
                n_err++; $display("FAIL call_ret_ysp[%0d]: got y=%h sp=%0d expected y=%h sp=%0d", i, y, sp, tbl[i].ey, esp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        stim_t tbl [10] = '{'{L, 16'h1000, 16'h1000}, '{C, 16'h2000, 16'h2000},
                            '{C, 16'h3000, 16'h3000}, '{C, 16'h4000, 16'h4000},
                            '{C, 16'h5000, 16'h5000}, '{C, 16'h6000, 16'h6000},
                            '{R, 16'h0000, 16'h4001}, '{R, 16'h0000, 16'h3001},
                            '{R, 16'h0000, 16'h2001}, '{R, 16'h0000, 16'h1001}};
        obs_t e, o;
        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].w);
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL overflow[%0d]: got %h expected %h", i, o, e); end
            n_cmp++;
            if (y !== tbl[i].ey) begin n_err++; $display("FAIL overflow_y[%0d]: got %h expected %h", i, y, tbl[i].ey); end
            if (i == 5) begin
                n_cmp++;
                if ({full, overflow, sp} !== {1'b1, 1'b1, 3'd4}) begin
                    n_err++; $display("FAIL overflow_flags: got full=%b ov=%b sp=%0d expected full=1 ov=1 sp=4", full, overflow, sp);
                end
            end
        end
    endtask

    task automatic test_underflow();
        stim_t tbl [4] = '{'{L, 16'h0042, 16'h0042}, '{R, 16'h0000, 16'h0042},
                           '{I, 16'h0000, 16'h0043}, '{N, 16'h0000, 16'h0043}};
        obs_t e, o;
        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].w);
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL underflow[%0d]: got %h expected %h", i, o, e); end
            n_cmp++;
            if (y !== tbl[i].ey || (i > 0 && underflow !== 1'b1)) begin
                n_err++; $display("FAIL underflow_y[%0d]: got y=%h un=%b expected y=%h un=1", i, y, underflow, tbl[i].ey);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t tbl [2] = '{'{C, 16'h0700, 16'h0700}, '{C, 16'h0800, 16'h0800}};
        obs_t e, o;
        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].w);
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL reset_mid[%0d]: got %h expected %h", i, o, e); end
        end
        reset = 1'b0;
        #2;
        model_reset();
        o = observe(); n_cmp++;
        if (o !== obs_t'{16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset_mid_clear: got %h expected %h", o,
                              obs_t'{16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        reset = 1'b1;
        drive(R, 16'h0000);
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e || y !== 16'h0000 || underflow !== 1'b1) begin
            n_err++; $display("FAIL reset_mid_ret: got %h expected %h", o, e);
        end
    endtask

    task automatic test_random();
        obs_t e, o;
        logic [4:0] c;
        for (int i = 0; i < 300; i++) begin
            c = 5'($urandom_range(0, 31));
            drive(c, 16'($urandom));
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL random[%0d] cmd=%b: got %h expected %h", i, c, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_load_inc();
        test_branch_wrap();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
